// File: rtl/bus_master_bridge.sv
// Peripheral bus request bridge: core requests queue in a small FIFO and are replayed one at a time
// onto the bus strobes. Define BUS_TIMEOUT_EN to abort strobes held longer than TIMEOUT cycles.
module bus_master_bridge #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] bus_address,
    output logic [DATA_W-1:0] bus_dataIn,
    output logic              bus_read,
    output logic              bus_write,
    input  logic [DATA_W-1:0] bus_dataOut,
    input  logic              bus_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("bus_master_bridge: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end

    // state  | meaning
    // IDLE   | waiting for a queued request; pops the FIFO head into the bus registers
    // ACCESS | one strobe high, waiting for bus_ready (or timeout)
    // RESP   | strobes low, resp_valid pulse
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;

    logic [ADDR_W-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_write;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next;
    logic                  push, pop;

    assign push = req_valid && req_ready;
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (!push && pop)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_data[wr_ptr]  <= req_wdata;
            fifo_write[wr_ptr] <= req_write;
        end
    end

    // req_ready tracks the post-update count, so a pop never frees a slot on the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_next;
            req_ready <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    assign resp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus_read    <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= '0;
            bus_dataIn  <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
`ifdef BUS_TIMEOUT_EN
            resp_error  <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus_address <= fifo_addr[rd_ptr];
                        bus_dataIn  <= fifo_data[rd_ptr];
                        bus_write   <= fifo_write[rd_ptr];
                        bus_read    <= !fifo_write[rd_ptr];
`ifdef BUS_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        resp_rdata <= bus_read ? bus_dataOut : '0;
`ifdef BUS_TIMEOUT_EN
                        resp_error <= 1'b0;
`endif
                        bus_read   <= 1'b0;
                        bus_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (timed_out) begin
                        resp_rdata <= '0;
                        resp_error <= 1'b1;
                        bus_read   <= 1'b0;
                        bus_write  <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_bridge.sv
// Scoreboard bench for bus_master_bridge: stimulus queues expected bus transfers and responses,
// independent monitors on the bus strobes and the response port pop and compare.
module tb_bus_master_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] bus_address, bus_dataIn, bus_dataOut;
    logic        bus_read, bus_write, bus_ready;

    always #5 clk = ~clk;

    bus_master_bridge dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .bus_address(bus_address), .bus_dataIn(bus_dataIn),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_dataOut(bus_dataOut), .bus_ready(bus_ready)
    );

    typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } bus_exp_t;
    typedef struct packed { logic [31:0] rd; logic err; } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int n_checks = 0, n_fail = 0;
    int n_acc = 0, n_resp = 0, n_rise = 0;
    int cyc = 0, last_acc_cyc = 0, last_resp_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0;
    logic bus_hold = 1'b0;
    int   bus_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h4000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Peripheral: raises bus_ready bus_lat cycles into a strobe unless held off
    initial begin
        int wc;
        wc = 0;
        bus_ready = 1'b0;
        bus_dataOut = '0;
        forever begin
            @(posedge clk); #1;
            bus_ready = 1'b0;
            if (bus_read || bus_write) begin
                bus_dataOut = rd_model(bus_address);
                if (!bus_hold && wc >= bus_lat) bus_ready = 1'b1;
                wc++;
            end else begin
                wc = 0;
            end
        end
    end

    logic prev_rv = 1'b0, prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (resp_valid) begin
            n_resp++;
            last_resp_cyc = cyc;
            chk("resp_single_cycle", prev_rv, 0);
            chk("resp_strobes_low", {bus_read, bus_write}, 0);
            chk("resp_expected", resp_q.size() != 0, 1);
            if (resp_q.size() != 0) begin
                resp_exp_t e;
                e = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_error", resp_error, e.err);
            end
        end
        prev_rv = resp_valid;
    end

    always @(negedge clk) begin
        if ((bus_read || bus_write) && !prev_strobe) begin
            n_rise++;
            last_rise_cyc = cyc;
            chk("strobe_onehot", bus_read & bus_write, 0);
            chk("bus_expected", bus_q.size() != 0, 1);
            if (bus_q.size() != 0) begin
                bus_exp_t e;
                e = bus_q.pop_front();
                chk("bus_write_dir", bus_write, e.w);
                chk("bus_address", bus_address, e.a);
                if (e.w) chk("bus_dataIn", bus_dataIn, e.d);
            end
        end
        if (!(bus_read || bus_write) && prev_strobe) last_fall_cyc = cyc;
        prev_strobe = bus_read || bus_write;
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
        int t;
        logic acc;
        t = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        do begin
            acc = req_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 200);
        req_valid = 1'b0;
        if (!acc) begin
            chk("push_accept_timeout", acc, 1);
        end else begin
            bus_q.push_back('{w: w, a: a, d: d});
            resp_q.push_back('{rd: exp_rd, err: exp_err});
            n_acc++;
            last_acc_cyc = cyc;
        end
    endtask

    task automatic wait_q(input int target);
        int t;
        t = 0;
        while (resp_q.size() > target && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("resp_queue_level", resp_q.size(), target);
    endtask

    initial begin
        int base, base_resp, base_rise;
        reset = 1'b0; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 32'h1234_5678; req_wdata = 32'h8765_4321;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_strobes", {bus_read, bus_write}, 0);
            chk("rst_resp", {resp_valid, resp_error}, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_bus_address", bus_address, 0);
            chk("rst_bus_dataIn", bus_dataIn, 0);
        end
        reset = 1'b1; req_valid = 1'b0;
        chk("ready_before_release_edge", req_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", req_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_enqueue_in_reset", n_rise, 0);

        // Single read, then a mixed pair with nonzero latency
        push(1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_q(0);
        chk("rd_latency", last_resp_cyc - last_acc_cyc, 2);
        chk("rd_strobe_start", last_rise_cyc - last_acc_cyc, 1);
        bus_lat = 2;
        push(1'b0, 32'h4000_0020, 32'h0, 32'h0020_C0DE, 1'b0);
        push(1'b1, 32'h5000_0004, 32'h1111_2222, 32'h0, 1'b0);
        wait_q(0);
        chk("lat2_strobe_width", last_fall_cyc - last_rise_cyc, 3);

        // Blocker holds ACCESS; 4 writes fill the FIFO, the 5th waits for a pop
        bus_lat = 0; bus_hold = 1'b1;
        push(1'b0, 32'h4000_0030, 32'h0, 32'h0030_C0DE, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    push(1'b1, 32'h5000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0, 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("b2b_accepts_until_full", n_acc - base, 4);
                chk("b2b_ready_when_full", req_ready, 0);
                bus_hold = 1'b0;
            end
        join
        chk("full_pop_accept_next_edge", last_acc_cyc - last_rise_cyc, 1);
        base_resp = n_resp;
        wait_q(0);
        chk("b2b_response_count", n_resp - base_resp, 5);

`ifdef BUS_TIMEOUT_EN
        bus_lat = 1000;
        push(1'b0, 32'h4000_0040, 32'h0, 32'h0, 1'b1);
        push(1'b1, 32'h5000_0200, 32'h0BAD_F00D, 32'h0, 1'b0);
        wait_q(1);
        chk("timeout_strobe_width", last_fall_cyc - last_rise_cyc, 16);
        bus_lat = 0;
        wait_q(0);
        bus_lat = 15;
        push(1'b0, 32'h4000_0050, 32'h0, 32'h0050_C0DE, 1'b0);
        wait_q(0);
        chk("ready_on_last_cycle_width", last_fall_cyc - last_rise_cyc, 16);
`else
        bus_lat = 20;
        push(1'b0, 32'h4000_0050, 32'h0, 32'h0050_C0DE, 1'b0);
        wait_q(0);
        chk("long_wait_strobe_width", last_fall_cyc - last_rise_cyc, 21);
`endif

        // Reset while a write is on the bus with two more queued
        bus_lat = 0; bus_hold = 1'b1;
        push(1'b1, 32'h5000_0300, 32'h3333_0000, 32'h0, 1'b0);
        push(1'b1, 32'h5000_0304, 32'h3333_0001, 32'h0, 1'b0);
        push(1'b1, 32'h5000_0308, 32'h3333_0002, 32'h0, 1'b0);
        chk("rst_mid_in_access", bus_write, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rst_mid_strobe_low", {bus_read, bus_write}, 0);
        bus_q.delete();
        resp_q.delete();
        base_resp = n_resp;
        base_rise = n_rise;
        bus_hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_no_resp", n_resp - base_resp, 0);
        chk("rst_mid_fifo_empty", n_rise - base_rise, 0);
        chk("rst_mid_ready", req_ready, 1);

        push(1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
        wait_q(0);
        chk("bus_queue_drained", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
